mem_line_ctrl: RTL and testbench
================================

Name: mem_line_ctrl

Overview:
- Initiator side of the main-memory interface: accepts line-sized read (fill) or write (write-back) requests from a cache/pipeline and sequences them as single-word accesses on main memory's addr / data_to_write / wrt_en / data_to_read port.
- Models a fixed memory access latency with a counter.
- Assembles the words of a read into one line and signals completion with a one-cycle response strobe.
- Sits between the cache/fetch logic and main_memory.

Parameters:
- ADDR_W, `MEM_ADDRESS_LEN (20): byte address width.
- DATA_W, `MEM_DATA_WIDTH (32): word width.
- LINE_WORDS, 4: words per line; must be a power of 2 and ≥2.
- MEM_LATENCY, 2: cycles each word access is held on the memory port; must be ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_wr  in  1  1 = write line, 0 = read line.
- req_addr  in  ADDR_W  byte address inside the target line.
- req_wdata  in  LINE_WORDS*DATA_W  line to write; word i at bits [DATA_W*i +: DATA_W].
- resp_valid  out  1  one-cycle done strobe.
- resp_data  out  LINE_WORDS*DATA_W  filled line, same word packing as req_wdata.
- mem_addr  out  ADDR_W  to main_memory addr.
- mem_data_to_write  out  DATA_W  to main_memory data_to_write.
- mem_wrt_en  out  1  to main_memory wrt_en.
- mem_data_to_read  in  DATA_W  from main_memory data_to_read; combinational from mem_addr.

Behaviour:
- Single clock clk. reset is synchronous and active-high.
- Reset values:
  - req_ready = 1; resp_valid = 0; resp_data = 0.
  - mem_addr = 0; mem_data_to_write = 0; mem_wrt_en = 0.
  - State = IDLE; all counters = 0.
- Reset applied mid-operation aborts the transfer. mem_wrt_en drops at that clock edge, so no further memory writes occur. resp_valid is not generated for the aborted request.
- All outputs are registered.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: req_ready = 1. On req_valid && req_ready:
    - latch req_wr and req_wdata;
    - base = req_addr with its low log2(LINE_WORDS*4) bits forced to 0;
    - word index idx = 0, beat count = 0, latency count = 0;
    - go to ACCESS.
  - ACCESS: req_ready = 0.
    - Drive mem_addr = base + 4*idx, truncated to ADDR_W. No carry can occur because base is aligned.
    - For writes: mem_data_to_write = latched word idx and mem_wrt_en = 1 for every ACCESS cycle. For reads: mem_wrt_en = 0.
    - The latency counter counts 0..MEM_LATENCY-1.
    - In the last cycle of a window, a read captures mem_data_to_read into resp_data word idx. Then idx = (idx+1) mod LINE_WORDS and beat count increments.
    - After beat LINE_WORDS-1, go to DONE with mem_wrt_en = 0 and mem_addr = 0.
  - DONE: resp_valid = 1 for exactly one cycle; req_ready = 0. Next state is IDLE.
- Latency: the acceptance edge is T. Word k occupies cycles T+1+k*MEM_LATENCY .. T+(k+1)*MEM_LATENCY. resp_valid is high in cycle T + LINE_WORDS*MEM_LATENCY + 1.
- Write responses: resp_valid pulses and resp_data keeps its previous value.
- resp_data holds the last filled line until the next read overwrites it word by word.
- req_valid while the controller is busy (ACCESS or DONE) is ignored. The requester holds the request until req_ready = 1.
- Back-to-back requests: the earliest next acceptance is the IDLE cycle after DONE.
- Top-of-memory line (base = 2^ADDR_W - 4*LINE_WORDS) is legal. Addresses never wrap past 2^ADDR_W.

Optional Feature:
- Macro: MEM_CTRL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Initial idx = req_addr[log2(LINE_WORDS*4)-1:2].
  - Words are accessed idx, idx+1, … mod LINE_WORDS.
  - resp_data packing is unchanged (word i at slot i).
  - An extra output crit_valid (1 bit) pulses in the cycle after the first word is captured, on reads only. It qualifies resp_data word [initial idx].
- Undefined:
  - Accesses always start at word 0.
  - The crit_valid port does not exist.

Test Plan:
- Reset, then idle for 5 cycles -> req_ready = 1, resp_valid = 0, mem_wrt_en = 0, mem_addr = 0, resp_data = 0 throughout.
- Memory preloaded: words at 0x100, 0x104, 0x108, 0x10C = 0xA0, 0xA1, 0xA2, 0xA3. Read with req_addr = 0x108, L = 2, W = 4 -> mem_addr sequence 0x100 ×2, 0x104 ×2, 0x108 ×2, 0x10C ×2. resp_valid is high 9 cycles after acceptance. resp_data = {0xA3, 0xA2, 0xA1, 0xA0}.
- Write of line {4, 3, 2, 1} at 0x200 -> mem_wrt_en high for 8 cycles with mem_data_to_write 1, 2, 3, 4 at 0x200/0x204/0x208/0x20C. A following read of 0x200 returns {4, 3, 2, 1}.
- req_valid held high during a transfer with a second address 0x300 -> the second request is accepted only in the IDLE cycle after resp_valid. No mem_addr 0x3xx appears before that.
- Reset asserted in the 3rd ACCESS cycle of a write to 0x400 -> mem_wrt_en = 0 from the next cycle, no resp_valid, and words 0x408/0x40C are unchanged in memory.
- With MEM_CTRL_CRITICAL_WORD_FIRST_EN, reading req_addr = 0x108 (same preload) -> mem_addr order 0x108, 0x10C, 0x100, 0x104. crit_valid pulses 3 cycles after acceptance with resp_data word2 = 0xA2. Final resp_data = {0xA3, 0xA2, 0xA1, 0xA0}.

Source files
------------

// File: rtl/mem_line_ctrl.sv
// Line-granular main-memory initiator: splits line reads/writes into single-word accesses held for MEM_LATENCY cycles.
// Optional macro MEM_CTRL_CRITICAL_WORD_FIRST_EN starts at the requested word and adds the crit_valid output.
module mem_line_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wr,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [LINE_WORDS*DATA_W-1:0] req_wdata,
  output logic                         resp_valid,
  output logic [LINE_WORDS*DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_data_to_write,
  output logic                         mem_wrt_en,
  input  logic [DATA_W-1:0]            mem_data_to_read
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
  ,
  output logic                         crit_valid
`endif
);

  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int LAT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int LINE_W = LINE_WORDS * DATA_W;
  localparam int TAG_W  = ADDR_W - OFF_W;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q;
  logic [TAG_W-1:0]    lineTag_q;
  logic                wr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    beat_q;
  logic [LAT_W-1:0]    lat_q;
  logic                reqReady_q;
  logic                respValid_q;
  logic [LINE_W-1:0]   respData_q;
  logic [ADDR_W-1:0]   memAddr_q;
  logic [DATA_W-1:0]   memWdata_q;
  logic                memWrtEn_q;
  logic                critValid_q;

  logic [TAG_W-1:0]    reqTag_d;
  logic [IDX_W-1:0]    startIdx_d;
  logic [IDX_W-1:0]    idx_d;
  logic                lastLat_d;
  logic                lastBeat_d;
  logic                unused_addr_bits;

  assign reqTag_d   = req_addr[ADDR_W-1:OFF_W];
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
  assign startIdx_d = req_addr[OFF_W-1:2];
`else
  assign startIdx_d = '0;
`endif
  assign idx_d      = idx_q + 1'b1;
  assign lastLat_d  = (lat_q == LAT_W'(MEM_LATENCY - 1));
  assign lastBeat_d = (beat_q == IDX_W'(LINE_WORDS - 1));
  assign unused_addr_bits = ^req_addr[OFF_W-1:0];

  // Word addresses are built by concatenation: the line base is aligned, so base + 4*idx never carries.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lineTag_q   <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      idx_q       <= '0;
      beat_q      <= '0;
      lat_q       <= '0;
      reqReady_q  <= 1'b1;
      respValid_q <= 1'b0;
      respData_q  <= '0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      memWrtEn_q  <= 1'b0;
      critValid_q <= 1'b0;
    end else begin
      respValid_q <= 1'b0;
      critValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q    <= ACCESS;
            reqReady_q <= 1'b0;
            wr_q       <= req_wr;
            wdata_q    <= req_wdata;
            lineTag_q  <= reqTag_d;
            idx_q      <= startIdx_d;
            beat_q     <= '0;
            lat_q      <= '0;
            memAddr_q  <= {reqTag_d, startIdx_d, 2'b00};
            memWdata_q <= req_wdata[startIdx_d*DATA_W +: DATA_W];
            memWrtEn_q <= req_wr;
          end
        end
        ACCESS: begin
          if (lastLat_d) begin
            lat_q <= '0;
            if (!wr_q) begin
              respData_q[idx_q*DATA_W +: DATA_W] <= mem_data_to_read;
              critValid_q <= (beat_q == '0);
            end
            if (lastBeat_d) begin
              state_q     <= DONE;
              respValid_q <= 1'b1;
              memWrtEn_q  <= 1'b0;
              memAddr_q   <= '0;
            end else begin
              idx_q      <= idx_d;
              beat_q     <= beat_q + 1'b1;
              memAddr_q  <= {lineTag_q, idx_d, 2'b00};
              memWdata_q <= wdata_q[idx_d*DATA_W +: DATA_W];
            end
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          reqReady_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready         = reqReady_q;
  assign resp_valid        = respValid_q;
  assign resp_data         = respData_q;
  assign mem_addr          = memAddr_q;
  assign mem_data_to_write = memWdata_q;
  assign mem_wrt_en        = memWrtEn_q;
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
  assign crit_valid        = critValid_q;
`else
  logic unused_crit;
  assign unused_crit = critValid_q;
`endif

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Self-checking bench for mem_line_ctrl: small word memory stub plus a line-level reference model.
// Works with or without MEM_CTRL_CRITICAL_WORD_FIRST_EN defined.
module tb_mem_line_ctrl;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
  localparam int LW     = 4;
  localparam int L      = 2;
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [19:0]   req_addr;
  logic [127:0]  req_wdata;
  logic          resp_valid;
  logic [127:0]  resp_data;
  logic [19:0]   mem_addr;
  logic [31:0]   mem_data_to_write;
  logic          mem_wrt_en;
  logic [31:0]   mem_data_to_read;
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
  logic          crit_valid;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0]  memArr [0:1023];
  logic [31:0]  refMem [0:1023];
  logic [127:0] lastLine;
  logic         fillEn;
  logic         pokeEn;
  logic [9:0]   pokeIdx;
  logic [31:0]  pokeData;

  logic [19:0]  traceA[$];
  logic         traceW[$];
  logic [31:0]  traceD[$];
  logic [19:0]  expA[$];
  logic         expW[$];
  logic [31:0]  expD[$];
  logic         doneWe;
  logic [19:0]  doneAddr;

  mem_line_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW), .MEM_LATENCY(L)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr(req_wr),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .mem_addr(mem_addr),
    .mem_data_to_write(mem_data_to_write),
    .mem_wrt_en(mem_wrt_en),
    .mem_data_to_read(mem_data_to_read)
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
    ,
    .crit_valid(crit_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(int i);
    return {16'h5A5A, 16'(i * 13 + 7)};
  endfunction

  // Memory stub: 4 KB window, combinational read, clocked write; the bench can bulk-fill or poke it.
  assign mem_data_to_read = memArr[mem_addr[11:2]];
  always @(posedge clk) begin
    if (fillEn) begin
      for (int i = 0; i < 1024; i++) memArr[i] <= initWord(i);
    end else if (mem_wrt_en) begin
      memArr[mem_addr[11:2]] <= mem_data_to_write;
    end else if (pokeEn) begin
      memArr[pokeIdx] <= pokeData;
    end
  end

  function automatic int startOf(logic [19:0] a);
    return CWF ? int'(a[3:2]) : 0;
  endfunction

  function automatic logic [127:0] refLine(logic [19:0] a);
    logic [127:0] r;
    for (int i = 0; i < LW; i++) r[i*32 +: 32] = refMem[{a[11:4], 2'(i)}];
    return r;
  endfunction

  // Expected memory-port trace: every word of the line, in access order, held for L cycles.
  function automatic void buildExp(logic wr, logic [19:0] a, logic [127:0] line);
    int s;
    int w;
    s = startOf(a);
    expA.delete(); expW.delete(); expD.delete();
    for (int k = 0; k < LW; k++) begin
      w = (s + k) % LW;
      for (int l = 0; l < L; l++) begin
        expA.push_back({a[19:4], 4'b0000} + 20'(4 * w));
        expW.push_back(wr);
        expD.push_back(line[w*32 +: 32]);
      end
    end
  endfunction

  task automatic poke(input logic [19:0] a, input logic [31:0] d);
    @(negedge clk);
    pokeEn = 1'b1; pokeIdx = a[11:2]; pokeData = d;
    @(negedge clk);
    pokeEn = 1'b0;
    refMem[a[11:2]] = d;
  endtask

  task automatic applyStimulus(input logic wr, input logic [19:0] a, input logic [127:0] line,
                               output int respN, output logic [127:0] respLine,
                               output int critN, output logic [31:0] critWord);
    int guard;
    traceA.delete(); traceW.delete(); traceD.delete();
    respN = -1; critN = -1; respLine = '0; critWord = '0; doneWe = 1'bx; doneAddr = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = line;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        respN = n; respLine = resp_data; doneWe = mem_wrt_en; doneAddr = mem_addr;
        break;
      end
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
      if (crit_valid === 1'b1 && critN < 0) begin
        critN = n; critWord = resp_data[startOf(a)*32 +: 32];
      end
`endif
      traceA.push_back(mem_addr); traceW.push_back(mem_wrt_en); traceD.push_back(mem_data_to_write);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_wrt_en !== 1'b0 || mem_addr !== 20'h0
          || resp_data !== 128'h0 || mem_data_to_write !== 32'h0) begin
        bad++;
        $display("[TB] FAIL reset_idle c%0d: got rdy=%b rv=%b we=%b addr=%h wd=%h rd=%h, want 1 0 0 0 0 0",
                 c, req_ready, resp_valid, mem_wrt_en, mem_addr, mem_data_to_write, resp_data);
      end
    end
  endtask

  task automatic test_read_fill();
    int respN, critN, fb;
    bit ok;
    logic [127:0] respLine;
    logic [31:0] critWord;
    poke(20'h00100, 32'hA0); poke(20'h00104, 32'hA1); poke(20'h00108, 32'hA2); poke(20'h0010C, 32'hA3);
    buildExp(1'b0, 20'h00108, 128'h0);
    applyStimulus(1'b0, 20'h00108, 128'h0, respN, respLine, critN, critWord);
    total++; ok = (traceA.size() == expA.size()); fb = -1;
    for (int i = 0; i < expA.size() && ok; i++)
      if (traceA[i] !== expA[i] || traceW[i] !== expW[i]) begin ok = 0; fb = i; end
    if (!ok) begin
      bad++;
      if (fb < 0) $display("[TB] FAIL read_trace: got %0d access cycles, want %0d", traceA.size(), expA.size());
      else $display("[TB] FAIL read_trace: cycle %0d got addr=%h we=%b, want addr=%h we=%b",
                    fb + 1, traceA[fb], traceW[fb], expA[fb], expW[fb]);
    end
    total++;
    if (respN !== LW * L + 1) begin
      bad++; $display("[TB] FAIL read_latency: got %0d, want %0d", respN, LW * L + 1);
    end
    total++;
    if (respLine !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
      bad++; $display("[TB] FAIL read_data: got %h, want %h", respLine, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    end
    total++;
    if (doneWe !== 1'b0 || doneAddr !== 20'h0) begin
      bad++; $display("[TB] FAIL done_port: got we=%b addr=%h, want 0 0", doneWe, doneAddr);
    end
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
    total++;
    if (critN !== L + 1 || critWord !== 32'hA2) begin
      bad++; $display("[TB] FAIL crit_word: got cycle %0d word %h, want cycle %0d word a2", critN, critWord, L + 1);
    end
`endif
    lastLine = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  endtask

  task automatic test_write_line();
    int respN, critN, fb;
    bit ok;
    logic [127:0] respLine, line;
    logic [31:0] critWord;
    line = {32'd4, 32'd3, 32'd2, 32'd1};
    buildExp(1'b1, 20'h00200, line);
    applyStimulus(1'b1, 20'h00200, line, respN, respLine, critN, critWord);
    total++; ok = (traceA.size() == expA.size()); fb = -1;
    for (int i = 0; i < expA.size() && ok; i++)
      if (traceA[i] !== expA[i] || traceW[i] !== expW[i] || traceD[i] !== expD[i]) begin ok = 0; fb = i; end
    if (!ok) begin
      bad++;
      if (fb < 0) $display("[TB] FAIL write_trace: got %0d access cycles, want %0d", traceA.size(), expA.size());
      else $display("[TB] FAIL write_trace: cycle %0d got addr=%h we=%b wd=%h, want addr=%h we=%b wd=%h",
                    fb + 1, traceA[fb], traceW[fb], traceD[fb], expA[fb], expW[fb], expD[fb]);
    end
    total++;
    if (respN !== LW * L + 1 || respLine !== lastLine) begin
      bad++; $display("[TB] FAIL write_resp: got cycle %0d data %h, want cycle %0d data %h",
                      respN, respLine, LW * L + 1, lastLine);
    end
    for (int i = 0; i < LW; i++) refMem[{8'h20, 2'(i)}] = line[i*32 +: 32];
    applyStimulus(1'b0, 20'h00200, 128'h0, respN, respLine, critN, critWord);
    total++;
    if (respLine !== line) begin
      bad++; $display("[TB] FAIL write_readback: got %h, want %h", respLine, line);
    end
    lastLine = line;
  endtask

  task automatic test_back_to_back();
    int respN, gotSecond, guard;
    bit early, readyBusy;
    logic readyAfter;
    logic [19:0] addrAfter;
    logic [127:0] second;
    respN = -1; gotSecond = -1; early = 0; readyBusy = 0; readyAfter = 0; addrAfter = '0; second = '0;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 20'h00100; req_wdata = '0;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_addr = 20'h00300;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (respN < 0) begin
        if (mem_addr[19:8] === 12'h003) early = 1;
        if (req_ready !== 1'b0) readyBusy = 1;
        if (resp_valid === 1'b1) respN = n;
      end else if (n == respN + 1) begin
        readyAfter = req_ready;
      end else begin
        addrAfter = mem_addr;
        break;
      end
    end
    req_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin gotSecond = n; second = resp_data; break; end
    end
    total++;
    if (early || readyBusy || respN !== LW * L + 1) begin
      bad++; $display("[TB] FAIL busy_ignore: got early=%b readyBusy=%b resp=%0d, want 0 0 %0d",
                      early, readyBusy, respN, LW * L + 1);
    end
    total++;
    if (readyAfter !== 1'b1 || addrAfter !== 20'h00300) begin
      bad++; $display("[TB] FAIL next_accept: got rdy=%b addr=%h, want 1 00300", readyAfter, addrAfter);
    end
    total++;
    if (gotSecond !== LW * L || second !== refLine(20'h00300)) begin
      bad++; $display("[TB] FAIL second_resp: got cycle %0d data %h, want cycle %0d data %h",
                      gotSecond, second, LW * L, refLine(20'h00300));
    end
    lastLine = refLine(20'h00300);
  endtask

  task automatic test_reset_abort();
    logic [127:0] line;
    logic weBefore, weAfter, rdyAfter;
    logic [19:0] addrAfter;
    logic [127:0] rdAfter;
    bit sawResp, sawWe, memOk;
    int s, guard;
    line = {$urandom, $urandom, $urandom, $urandom};
    s = startOf(20'h00400);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 20'h00400; req_wdata = line;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    weBefore = mem_wrt_en;
    reset = 1'b1;
    @(negedge clk);
    weAfter = mem_wrt_en; rdyAfter = req_ready; addrAfter = mem_addr; rdAfter = resp_data;
    reset = 1'b0;
    sawResp = 0; sawWe = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) sawResp = 1;
      if (mem_wrt_en !== 1'b0) sawWe = 1;
    end
    // Only the first two words in access order reach memory before the reset edge.
    refMem[{8'h40, 2'(s % LW)}]       = line[(s % LW)*32 +: 32];
    refMem[{8'h40, 2'((s + 1) % LW)}] = line[((s + 1) % LW)*32 +: 32];
    lastLine = '0;
    memOk = 1;
    for (int i = 0; i < LW; i++) if (memArr[{8'h40, 2'(i)}] !== refMem[{8'h40, 2'(i)}]) memOk = 0;
    total++;
    if (weBefore !== 1'b1) begin
      bad++; $display("[TB] FAIL abort_pre_we: got %b, want 1", weBefore);
    end
    total++;
    if (weAfter !== 1'b0 || rdyAfter !== 1'b1 || addrAfter !== 20'h0 || rdAfter !== 128'h0) begin
      bad++; $display("[TB] FAIL abort_state: got we=%b rdy=%b addr=%h rd=%h, want 0 1 0 0",
                      weAfter, rdyAfter, addrAfter, rdAfter);
    end
    total++;
    if (sawResp || sawWe) begin
      bad++; $display("[TB] FAIL abort_quiet: got resp=%b we=%b, want 0 0", sawResp, sawWe);
    end
    total++;
    if (!memOk) begin
      bad++; $display("[TB] FAIL abort_mem: got %h %h %h %h, want %h %h %h %h",
                      memArr[10'h100], memArr[10'h101], memArr[10'h102], memArr[10'h103],
                      refMem[10'h100], refMem[10'h101], refMem[10'h102], refMem[10'h103]);
    end
  endtask

  // First two transactions exercise the top-of-memory line, the rest are random.
  task automatic test_random();
    int respN, critN, fb;
    bit ok;
    logic wr;
    logic [19:0] a;
    logic [127:0] line, respLine, expResp;
    logic [31:0] critWord;
    for (int it = 0; it < 14; it++) begin
      wr   = (it == 0) ? 1'b1 : (it == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      a    = (it == 0) ? 20'hFFFF8 : (it == 1) ? 20'hFFFF0 : 20'($urandom);
      line = {$urandom, $urandom, $urandom, $urandom};
      expResp = wr ? lastLine : refLine(a);
      buildExp(wr, a, line);
      applyStimulus(wr, a, line, respN, respLine, critN, critWord);
      total++; ok = (traceA.size() == expA.size()); fb = -1;
      for (int i = 0; i < expA.size() && ok; i++)
        if (traceA[i] !== expA[i] || traceW[i] !== expW[i] || (expW[i] && traceD[i] !== expD[i])) begin
          ok = 0; fb = i;
        end
      if (!ok) begin
        bad++;
        if (fb < 0) $display("[TB] FAIL rand_trace it%0d: got %0d access cycles, want %0d", it, traceA.size(), expA.size());
        else $display("[TB] FAIL rand_trace it%0d: cycle %0d got addr=%h we=%b wd=%h, want addr=%h we=%b wd=%h",
                      it, fb + 1, traceA[fb], traceW[fb], traceD[fb], expA[fb], expW[fb], expD[fb]);
      end
      total++;
      if (respN !== LW * L + 1 || respLine !== expResp) begin
        bad++; $display("[TB] FAIL rand_resp it%0d: got cycle %0d data %h, want cycle %0d data %h",
                        it, respN, respLine, LW * L + 1, expResp);
      end
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
      total++;
      if (!wr && (critN !== L + 1 || critWord !== expResp[startOf(a)*32 +: 32])) begin
        bad++; $display("[TB] FAIL rand_crit it%0d: got cycle %0d word %h, want cycle %0d word %h",
                        it, critN, critWord, L + 1, expResp[startOf(a)*32 +: 32]);
      end
`endif
      if (wr) for (int i = 0; i < LW; i++) refMem[{a[11:4], 2'(i)}] = line[i*32 +: 32];
      else lastLine = expResp;
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    fillEn = 1'b1; pokeEn = 1'b0; pokeIdx = '0; pokeData = '0;
    lastLine = '0;
    for (int i = 0; i < 1024; i++) refMem[i] = initWord(i);
    repeat (3) @(negedge clk);
    fillEn = 1'b0;
    reset  = 1'b0;
    test_reset();
    test_read_fill();
    test_write_line();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
